// File: rtl/dmem_bridge_pkg.sv
// Shared types for the data-memory bridge: FSM state encoding and lane count.
package dmem_bridge_pkg;

    typedef enum logic [2:0] {
        DMEM_IDLE  = 3'd0,
        DMEM_REQ   = 3'd1,
        DMEM_RESP  = 3'd2,
        DMEM_DONE  = 3'd3,
        DMEM_DRAIN = 3'd4
    } dmem_state_e;

    localparam int DMEM_SEL_W = 4;

endpackage

// File: rtl/dmem_bridge.sv
// Converts the mem stage's chip-enable strobe into one valid/ready request plus
// response on the data bus, stalling the pipeline while the access is in flight.
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mem_ce_i,
    input  logic                    mem_we_i,
    input  logic [DATA_WIDTH/8-1:0] mem_sel_i,
    input  logic [ADDR_WIDTH-1:0]   mem_addr_i,
    input  logic [DATA_WIDTH-1:0]   mem_data_i,
    input  logic                    stall_i,
    input  logic                    flush_i,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    stallreq_o,
    output logic                    req_valid_o,
    input  logic                    req_ready_i,
    output logic                    req_we_o,
    output logic [DATA_WIDTH/8-1:0] req_sel_o,
    output logic [ADDR_WIDTH-1:0]   req_addr_o,
    output logic [DATA_WIDTH-1:0]   req_wdata_o,
    input  logic                    resp_valid_i,
    input  logic [DATA_WIDTH-1:0]   resp_data_i
);

    localparam int SEL_W = DATA_WIDTH / 8;

    dmem_state_e             state_q, state_d;
    logic                    drop_q, drop_d;
    logic                    we_q, we_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    stallreq;

    always_comb begin
        state_d  = state_q;
        drop_d   = drop_q;
        we_d     = we_q;
        sel_d    = sel_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        stallreq = 1'b0;

        unique case (state_q)
            DMEM_IDLE: begin
                drop_d = 1'b0;
                if (mem_ce_i && !flush_i) begin
                    stallreq = 1'b1;
                    we_d     = mem_we_i;
                    sel_d    = mem_sel_i;
                    addr_d   = {mem_addr_i[ADDR_WIDTH-1:2], 2'b00};
                    wdata_d  = mem_data_i;
                    state_d  = DMEM_REQ;
                end
            end
            DMEM_REQ: begin
                // A flush here cannot retract the request; it only marks the result for discard.
                stallreq = 1'b1;
                if (flush_i) drop_d = 1'b1;
                if (req_ready_i) state_d = (drop_q || flush_i) ? DMEM_DRAIN : DMEM_RESP;
            end
            DMEM_RESP: begin
                stallreq = 1'b1;
                if (resp_valid_i) begin
                    if (drop_q || flush_i) begin
                        drop_d  = 1'b0;
                        state_d = DMEM_IDLE;
                    end else begin
                        if (!we_q) rdata_d = resp_data_i;
                        state_d = DMEM_DONE;
                    end
                end else if (flush_i) begin
                    drop_d  = 1'b1;
                    state_d = DMEM_DRAIN;
                end
            end
            DMEM_DONE: begin
                // mem_ce_i is still high for the same instruction; never re-issue from here.
                if (flush_i || !stall_i) state_d = DMEM_IDLE;
            end
            DMEM_DRAIN: begin
                stallreq = 1'b1;
                if (resp_valid_i) begin
                    drop_d  = 1'b0;
                    state_d = DMEM_IDLE;
                end
            end
            default: state_d = DMEM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= DMEM_IDLE;
            drop_q  <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Payload is masked outside REQ so the bus sees zeros whenever valid is low.
    assign req_valid_o = (state_q == DMEM_REQ);
    assign req_we_o    = req_valid_o & we_q;
    assign req_sel_o   = req_valid_o ? sel_q   : '0;
    assign req_addr_o  = req_valid_o ? addr_q  : '0;
    assign req_wdata_o = req_valid_o ? wdata_q : '0;
    assign rdata_o     = rdata_q;
    assign stallreq_o  = rst & stallreq;

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: hand-computed expectations checked each cycle.
module tb_dmem_bridge;
    import dmem_bridge_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_ce_i, mem_we_i, stall_i, flush_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_addr_i, mem_data_i;
    logic [31:0] rdata_o;
    logic        stallreq_o, req_valid_o, req_ready_i, req_we_o;
    logic [3:0]  req_sel_o;
    logic [31:0] req_addr_o, req_wdata_o;
    logic        resp_valid_i;
    logic [31:0] resp_data_i;

    int vectors = 0;
    int miscompares = 0;

    dmem_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i),
        .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
        .stall_i(stall_i), .flush_i(flush_i),
        .rdata_o(rdata_o), .stallreq_o(stallreq_o),
        .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
        .req_we_o(req_we_o), .req_sel_o(req_sel_o),
        .req_addr_o(req_addr_o), .req_wdata_o(req_wdata_o),
        .resp_valid_i(resp_valid_i), .resp_data_i(resp_data_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; mem_ce_i = 0; mem_we_i = 0; mem_sel_i = 4'h0;
        mem_addr_i = '0; mem_data_i = '0; stall_i = 0; flush_i = 0;
        req_ready_i = 0; resp_valid_i = 0; resp_data_i = '0;

        // reset state
        #3;
        chk("rst_rdata", rdata_o, 0);
        chk("rst_stallreq", stallreq_o, 0);
        chk("rst_valid", req_valid_o, 0);
        chk("rst_addr", req_addr_o, 0);
        chk("rst_state", dut.state_q, DMEM_IDLE);
        tick(); tick();
        rst = 1'b1;

        // read 0x1004, immediate ready and response
        tick();
        mem_ce_i = 1; mem_we_i = 0; mem_sel_i = 4'hF; mem_addr_i = 32'h0000_1004; req_ready_i = 1;
        #1;
        chk("rd_c0_stallreq", stallreq_o, 1);
        chk("rd_c0_valid", req_valid_o, 0);
        tick(); #1;
        chk("rd_c1_valid", req_valid_o, 1);
        chk("rd_c1_addr", req_addr_o, 32'h0000_1004);
        chk("rd_c1_we", req_we_o, 0);
        chk("rd_c1_stallreq", stallreq_o, 1);
        tick();
        resp_valid_i = 1; resp_data_i = 32'hDEAD_BEEF;
        #1;
        chk("rd_c2_state", dut.state_q, DMEM_RESP);
        chk("rd_c2_stallreq", stallreq_o, 1);
        chk("rd_c2_valid", req_valid_o, 0);
        tick();
        resp_valid_i = 0;
        #1;
        chk("rd_c3_state", dut.state_q, DMEM_DONE);
        chk("rd_c3_stallreq", stallreq_o, 0);
        chk("rd_c3_rdata", rdata_o, 32'hDEAD_BEEF);
        tick();
        mem_ce_i = 0;
        #1;
        chk("rd_c4_state", dut.state_q, DMEM_IDLE);
        chk("rd_c4_stallreq", stallreq_o, 0);

        // byte store with ready delayed 4 cycles
        tick();
        mem_ce_i = 1; mem_we_i = 1; mem_sel_i = 4'b0010; mem_addr_i = 32'h0000_2002;
        mem_data_i = 32'h5A5A_5A5A; req_ready_i = 0;
        #1;
        chk("st_c0_stallreq", stallreq_o, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            mem_addr_i = 32'h0000_BAD0;
            mem_data_i = 32'h0;
            req_ready_i = (i == 4);
            #1;
            chk("st_valid", req_valid_o, 1);
            chk("st_addr", req_addr_o, 32'h0000_2000);
            chk("st_sel", req_sel_o, 4'b0010);
            chk("st_wdata", req_wdata_o, 32'h5A5A_5A5A);
            chk("st_we", req_we_o, 1);
        end
        tick();
        req_ready_i = 0; resp_valid_i = 1; resp_data_i = 32'h1111_1111;
        #1;
        chk("st_resp_state", dut.state_q, DMEM_RESP);
        chk("st_resp_valid", req_valid_o, 0);
        tick();
        resp_valid_i = 0;
        #1;
        chk("st_done_state", dut.state_q, DMEM_DONE);
        chk("st_rdata_kept", rdata_o, 32'hDEAD_BEEF);
        tick();
        mem_ce_i = 0; mem_we_i = 0;
        #1;
        chk("st_idle", dut.state_q, DMEM_IDLE);

        // read completing under external stall
        tick();
        mem_ce_i = 1; mem_sel_i = 4'hF; mem_addr_i = 32'h0000_3000; req_ready_i = 1;
        #1;
        tick(); #1;
        chk("sh_req_valid", req_valid_o, 1);
        tick();
        resp_valid_i = 1; resp_data_i = 32'hCAFE_F00D; stall_i = 1;
        #1;
        chk("sh_resp_state", dut.state_q, DMEM_RESP);
        tick();
        resp_valid_i = 0;
        #1;
        chk("sh_done_state", dut.state_q, DMEM_DONE);
        chk("sh_done_rdata", rdata_o, 32'hCAFE_F00D);
        chk("sh_done_stallreq", stallreq_o, 0);
        for (int i = 0; i < 2; i++) begin
            tick(); #1;
            chk("sh_hold_state", dut.state_q, DMEM_DONE);
            chk("sh_hold_valid", req_valid_o, 0);
            chk("sh_hold_rdata", rdata_o, 32'hCAFE_F00D);
        end
        tick();
        stall_i = 0;
        #1;
        chk("sh_fall_state", dut.state_q, DMEM_DONE);
        tick();
        mem_ce_i = 0;
        #1;
        chk("sh_idle_state", dut.state_q, DMEM_IDLE);
        chk("sh_idle_valid", req_valid_o, 0);

        // flush in REQ before handshake
        tick();
        mem_ce_i = 1; mem_addr_i = 32'h0000_4000; req_ready_i = 0;
        #1;
        tick();
        flush_i = 1;
        #1;
        chk("fl_c1_valid", req_valid_o, 1);
        chk("fl_c1_stallreq", stallreq_o, 1);
        tick();
        flush_i = 0; mem_ce_i = 0;
        #1;
        chk("fl_c2_valid", req_valid_o, 1);
        chk("fl_c2_addr", req_addr_o, 32'h0000_4000);
        tick();
        req_ready_i = 1;
        #1;
        chk("fl_c3_valid", req_valid_o, 1);
        tick();
        req_ready_i = 0;
        #1;
        chk("fl_drain_state", dut.state_q, DMEM_DRAIN);
        chk("fl_drain_stallreq", stallreq_o, 1);
        chk("fl_drain_valid", req_valid_o, 0);
        tick();
        resp_valid_i = 1; resp_data_i = 32'h1234_5678;
        #1;
        chk("fl_resp_stallreq", stallreq_o, 1);
        tick();
        resp_valid_i = 0;
        #1;
        chk("fl_idle_state", dut.state_q, DMEM_IDLE);
        chk("fl_rdata_kept", rdata_o, 32'hCAFE_F00D);
        chk("fl_idle_stallreq", stallreq_o, 0);

        // flush with mem_ce_i in the same IDLE cycle
        tick();
        mem_ce_i = 1; flush_i = 1; req_ready_i = 1;
        #1;
        chk("fc_stallreq", stallreq_o, 0);
        tick();
        mem_ce_i = 0; flush_i = 0;
        #1;
        chk("fc_state", dut.state_q, DMEM_IDLE);
        chk("fc_valid", req_valid_o, 0);

        // back-to-back reads at 0x10 and 0x14
        tick();
        mem_ce_i = 1; mem_addr_i = 32'h0000_0010;
        #1;
        tick(); #1;
        chk("bb1_addr", req_addr_o, 32'h0000_0010);
        tick();
        resp_valid_i = 1; resp_data_i = 32'h0000_000A;
        #1;
        tick();
        resp_valid_i = 0;
        #1;
        chk("bb1_rdata", rdata_o, 32'h0000_000A);
        chk("bb1_done", dut.state_q, DMEM_DONE);
        tick();
        mem_addr_i = 32'h0000_0014;
        #1;
        chk("bb2_idle_state", dut.state_q, DMEM_IDLE);
        chk("bb2_idle_stallreq", stallreq_o, 1);
        tick(); #1;
        chk("bb2_valid", req_valid_o, 1);
        chk("bb2_addr", req_addr_o, 32'h0000_0014);
        tick();
        resp_valid_i = 1; resp_data_i = 32'h0000_000B;
        #1;
        chk("bb2_rdata_before", rdata_o, 32'h0000_000A);
        tick();
        resp_valid_i = 0;
        #1;
        chk("bb2_rdata", rdata_o, 32'h0000_000B);
        tick();
        mem_ce_i = 0;
        #1;

        // flush coinciding with response in RESP
        tick();
        mem_ce_i = 1; mem_addr_i = 32'h0000_0020;
        #1;
        tick(); #1;
        tick();
        resp_valid_i = 1; resp_data_i = 32'h0000_0099; flush_i = 1;
        #1;
        tick();
        resp_valid_i = 0; flush_i = 0; mem_ce_i = 0;
        #1;
        chk("fr_state", dut.state_q, DMEM_IDLE);
        chk("fr_rdata", rdata_o, 32'h0000_000B);

        // reset asserted while in RESP
        tick();
        mem_ce_i = 1; mem_addr_i = 32'h0000_0030;
        #1;
        tick(); #1;
        tick(); #1;
        chk("rs_pre_state", dut.state_q, DMEM_RESP);
        rst = 1'b0;
        #1;
        chk("rs_state", dut.state_q, DMEM_IDLE);
        chk("rs_valid", req_valid_o, 0);
        chk("rs_stallreq", stallreq_o, 0);
        chk("rs_rdata", rdata_o, 0);
        chk("rs_addr", req_addr_o, 0);
        tick();
        rst = 1'b1; mem_ce_i = 0; resp_valid_i = 1; resp_data_i = 32'h0000_0077;
        #1;
        tick();
        resp_valid_i = 0;
        #1;
        chk("rs_after_state", dut.state_q, DMEM_IDLE);
        chk("rs_after_rdata", rdata_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
